// File: rtl/spi_controller_if.sv
// Host-side bus and SPI pins of the SPI mode-0 controller.
// The controller connects through the slave modport.
// The surrounding system, or a bench, connects through the master modport.
interface spi_controller_if #(
    parameter int MAX_LEN = 4
);
    logic                   start;
    logic [2:0]             length;
    logic [8*MAX_LEN-1:0]   tx_data;
    logic [8*MAX_LEN-1:0]   rx_data;
    logic                   busy;
    logic                   done;
    logic                   spi_sclk;
    logic                   spi_cs_n;
    logic                   spi_tx;
    logic                   spi_rx;

    modport master (
        output start, length, tx_data, spi_rx,
        input  rx_data, busy, done, spi_sclk, spi_cs_n, spi_tx
    );

    modport slave (
        input  start, length, tx_data, spi_rx,
        output rx_data, busy, done, spi_sclk, spi_cs_n, spi_tx
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 master for the PET clone.
// Shifts up to MAX_LEN bytes out MSB-first, byte 0 first, and captures as many bytes back.
// Each SCLK half-period lasts CLK_DIV clk cycles.
// Every SPI pin comes straight from a flop.
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 4
) (
    input  logic            clk,
    input  logic            reset,
    spi_controller_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t               state;
    state_t               state_n;

    logic [CW-1:0]        half_cnt;
    logic [2:0]           bit_cnt;
    logic [BW-1:0]        byte_cnt;
    logic [BW-1:0]        last_byte;
    logic [BW-1:0]        last_byte_n;
    logic [31:0]          len_clamped;

    logic [7:0]           tx_mem [MAX_LEN];
    logic [6:0]           shift_in;
    logic [8*MAX_LEN-1:0] rx_q;

    logic                 sclk_q;
    logic                 cs_n_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 phase_end;
    logic                 last_bit;
    logic                 next_tx;
    logic                 load;
    logic                 load_empty;
    logic                 rise;
    logic                 fall_next;
    logic                 fall_last;
    logic                 cs_release;
    logic                 finish;

    // Clamp the requested byte count and turn it into the index of the last byte.
    always_comb begin
        len_clamped = {29'd0, bus.length};
        if (len_clamped > MAX_LEN) begin
            len_clamped = MAX_LEN;
        end
        last_byte_n = BW'(len_clamped - 32'd1);
    end

    // Pick the MOSI bit for the next falling edge; after bit 0 the next byte's MSB follows.
    always_comb begin
        phase_end = (half_cnt == HALF_LAST);
        last_bit  = (bit_cnt == 3'd7) && (byte_cnt == last_byte);
        if (bit_cnt == 3'd7) begin
            next_tx = tx_mem[byte_cnt + BW'(1)][7];
        end else begin
            next_tx = tx_mem[byte_cnt][3'd6 - bit_cnt];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and the one-cycle control strobes for the datapath.
    always_comb begin
        state_n    = state;
        load       = 1'b0;
        load_empty = 1'b0;
        rise       = 1'b0;
        fall_next  = 1'b0;
        fall_last  = 1'b0;
        cs_release = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !done_q) begin
                    if (bus.length == 3'd0) begin
                        load_empty = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_n = SETUP;
                    end
                end
            end
            SETUP: begin
                if (phase_end) begin
                    rise    = 1'b1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    if (last_bit) begin
                        fall_last = 1'b1;
                        state_n   = HOLD;
                    end else begin
                        fall_next = 1'b1;
                        state_n   = LOW;
                    end
                end
            end
            LOW: begin
                if (phase_end) begin
                    rise    = 1'b1;
                    state_n = HIGH;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    cs_release = 1'b1;
                    state_n    = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Half-period, bit and byte counters.
    // The half-period counter restarts at every phase change and rests at 0 while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt  <= '0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            last_byte <= '0;
        end else begin
            if (state == IDLE || phase_end) begin
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + CW'(1);
            end
            if (load) begin
                bit_cnt   <= 3'd0;
                byte_cnt  <= '0;
                last_byte <= last_byte_n;
            end else if (fall_next) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_cnt <= byte_cnt + BW'(1);
                end
            end
        end
    end

    // Latch the outgoing bytes at start.
    // On each rising SCLK, shift MISO in and commit a finished byte to its slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_in <= 7'd0;
            rx_q     <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                tx_mem[i] <= 8'h00;
            end
        end else begin
            if (load) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    tx_mem[i] <= bus.tx_data[8*i +: 8];
                end
            end
            if (rise) begin
                shift_in <= {shift_in[5:0], bus.spi_rx};
                if (bit_cnt == 3'd7) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (byte_cnt == BW'(i)) begin
                            rx_q[8*i +: 8] <= {shift_in, bus.spi_rx};
                        end
                    end
                end
            end
        end
    end

    // Registered SPI pins and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
            tx_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish | load_empty;
            if (rise) begin
                sclk_q <= 1'b1;
            end else if (fall_next || fall_last) begin
                sclk_q <= 1'b0;
            end
            if (load) begin
                cs_n_q <= 1'b0;
                busy_q <= 1'b1;
                tx_q   <= bus.tx_data[7];
            end else begin
                if (cs_release) begin
                    cs_n_q <= 1'b1;
                end
                if (finish) begin
                    busy_q <= 1'b0;
                end
                if (fall_next) begin
                    tx_q <= next_tx;
                end
            end
        end
    end

    assign bus.spi_sclk = sclk_q;
    assign bus.spi_cs_n = cs_n_q;
    assign bus.spi_tx   = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller.
// A behavioural SPI mode-0 target answers the controller.
// Each start pushes its expected result onto a scoreboard queue.
// A monitor pops and compares the entry when done pulses.
module tb_spi_controller;
    localparam int D    = 2;
    localparam int MAXL = 4;

    typedef struct {
        int          acc;
        int          n;
        logic [31:0] rx;
        logic [31:0] mosi;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    spi_controller_if #(.MAX_LEN(MAXL)) bus ();

    spi_controller #(.CLK_DIV(D), .MAX_LEN(MAXL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        scoreboard [$];
    int          check_count = 0;
    int          pass_count  = 0;
    int          cyc         = 0;
    logic [31:0] rx_model    = 32'd0;
    logic [31:0] target_resp = 32'd0;
    logic [31:0] target_shift;
    logic        target_active = 1'b0;

    int          cs_fall_cyc    = -1;
    int          cs_rise_cyc    = -1;
    int          first_rise_cyc = -1;
    int          last_fall_cyc  = -1;
    int          rise_count     = 0;
    logic [31:0] mosi_cap       = 32'd0;
    logic        cs_fell        = 1'b0;
    logic        busy_seen      = 1'b0;
    logic        prev_sclk      = 1'b0;
    logic        prev_cs        = 1'b1;
    logic        prev_done      = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Cycle count, advanced on the active edge and read away from it.
    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 target: preload the first bit when CS falls and shift on each SCLK fall.
    always @(negedge bus.spi_cs_n or posedge bus.spi_cs_n or negedge bus.spi_sclk) begin
        if (bus.spi_cs_n !== 1'b0) begin
            target_active = 1'b0;
        end else if (!target_active) begin
            target_active = 1'b1;
            target_shift  = {target_resp[7:0], target_resp[15:8], target_resp[23:16], target_resp[31:24]};
            bus.spi_rx    = target_shift[31];
        end else begin
            target_shift = target_shift << 1;
            bus.spi_rx   = target_shift[31];
        end
    end

    // Monitor: track pin activity each cycle and score a transaction when done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rise_count     = 0;
            mosi_cap       = 32'd0;
            cs_fell        = 1'b0;
            busy_seen      = 1'b0;
            first_rise_cyc = -1;
            cs_rise_cyc    = -1;
            prev_sclk      = 1'b0;
            prev_cs        = 1'b1;
            prev_done      = 1'b0;
        end else begin
            if (bus.busy) busy_seen = 1'b1;
            if (prev_cs && !bus.spi_cs_n) begin
                if (cs_rise_cyc >= 0) checkOutput("cs_gap_ge_D", 32'((cyc - cs_rise_cyc) >= D), 32'd1);
                cs_fall_cyc    = cyc;
                cs_fell        = 1'b1;
                rise_count     = 0;
                mosi_cap       = 32'd0;
                first_rise_cyc = -1;
            end
            if (!prev_cs && bus.spi_cs_n) cs_rise_cyc = cyc;
            if (!prev_sclk && bus.spi_sclk) begin
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
                rise_count++;
                mosi_cap = {mosi_cap[30:0], bus.spi_tx};
            end
            if (prev_sclk && !bus.spi_sclk) last_fall_cyc = cyc;
            if (bus.done) begin
                checkOutput("done_width", 32'(prev_done), 32'd0);
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("rx_data", bus.rx_data, e.rx);
                    if (e.n == 0) begin
                        checkOutput("done_cycle_len0", 32'(cyc - e.acc + 1), 32'd1);
                        checkOutput("cs_quiet_len0", 32'(cs_fell), 32'd0);
                        checkOutput("busy_quiet_len0", 32'(busy_seen), 32'd0);
                    end else begin
                        checkOutput("done_cycle", 32'(cyc - e.acc + 1), 32'(1 + 16*e.n*D + 2*D));
                        checkOutput("cs_fall_cycle", 32'(cs_fall_cyc - e.acc + 1), 32'd1);
                        checkOutput("first_rise_cycle", 32'(first_rise_cyc - e.acc + 1), 32'(1 + D));
                        checkOutput("last_fall_cycle", 32'(last_fall_cyc - e.acc + 1), 32'(1 + 16*e.n*D));
                        checkOutput("cs_rise_cycle", 32'(cs_rise_cyc - e.acc + 1), 32'(1 + 16*e.n*D + D));
                        checkOutput("sclk_rises", 32'(rise_count), 32'(8*e.n));
                        checkOutput("mosi_bits", mosi_cap, e.mosi);
                        checkOutput("busy_seen", 32'(busy_seen), 32'd1);
                    end
                end
                cs_fell    = 1'b0;
                busy_seen  = 1'b0;
                rise_count = 0;
            end
            prev_sclk = bus.spi_sclk;
            prev_cs   = bus.spi_cs_n;
            prev_done = bus.done;
        end
    end

    // Build the expected result of one transaction and update the rx model.
    function automatic exp_t makeExpected(input int acc, input int len, input logic [31:0] tx,
                                          input logic [31:0] resp);
        exp_t e;
        e.acc  = acc;
        e.n    = (len > MAXL) ? MAXL : len;
        e.mosi = 32'd0;
        for (int i = 0; i < e.n; i++) begin
            e.mosi = {e.mosi[23:0], tx[8*i +: 8]};
            rx_model[8*i +: 8] = resp[8*i +: 8];
        end
        e.rx = rx_model;
        return e;
    endfunction

    task automatic applyStimulus(input int len, input logic [31:0] tx, input logic [31:0] resp);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.length  = 3'(len);
        bus.tx_data = tx;
        target_resp = resp;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.tx_data = 32'hDEADBEEF;
        bus.length  = 3'd7;
        scoreboard.push_back(makeExpected(cyc, len, tx, resp));
    endtask

    task automatic waitIdle(input string tag);
        int guard = 0;
        while (scoreboard.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(tag, 32'(scoreboard.size()), 32'd0);
        scoreboard.delete();
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_sclk", 32'(bus.spi_sclk), 32'd0);
        checkOutput("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
        checkOutput("rst_tx", 32'(bus.spi_tx), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_rx_data", bus.rx_data, 32'd0);
        reset    = 1'b0;
        rx_model = 32'd0;
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        exp_t e;
        int   acc;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.length  = 3'd0;
        bus.tx_data = 32'd0;
        repeat (2) @(posedge clk);
        pulseReset();

        $display("[TB] single byte 0xA5 out, 0x3C back");
        applyStimulus(1, 32'h000000A5, 32'h0000003C);
        waitIdle("complete_len1");

        $display("[TB] four bytes");
        applyStimulus(4, 32'h44332211, 32'hDDCCBBAA);
        waitIdle("complete_len4");

        $display("[TB] clamp length 6 after reset, then partial length 2");
        pulseReset();
        applyStimulus(6, 32'h87654321, 32'h12345678);
        waitIdle("complete_len6");
        applyStimulus(2, 32'h0000FFFF, 32'h55AA9ABC);
        waitIdle("complete_len2");

        $display("[TB] zero length");
        applyStimulus(0, 32'h000000FF, 32'hFFFFFFFF);
        waitIdle("complete_len0");

        $display("[TB] start held high across three transactions");
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.length  = 3'd1;
        bus.tx_data = 32'h00000081;
        target_resp = 32'h0000007E;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 3; k++) begin
            scoreboard.push_back(makeExpected(acc + k*(16*D + 2*D + 2), 1, 32'h00000081, 32'h0000007E));
        end
        waitIdle("complete_held");
        bus.start = 1'b0;
        repeat (3*D) @(posedge clk);
        #1;
        checkOutput("held_stop_cs_n", 32'(bus.spi_cs_n), 32'd1);
        checkOutput("held_stop_busy", 32'(bus.busy), 32'd0);

        $display("[TB] reset in the middle of byte 1");
        applyStimulus(2, 32'h0000C3A5, 32'h00005A96);
        repeat (21*D) @(posedge clk);
        #1;
        checkOutput("pre_reset_sclk", 32'(bus.spi_sclk), 32'd1);
        checkOutput("pre_reset_rx_byte0", 32'(bus.rx_data[7:0]), 32'h96);
        reset = 1'b1;
        scoreboard.delete();
        @(posedge clk);
        #1;
        checkOutput("abort_sclk", 32'(bus.spi_sclk), 32'd0);
        checkOutput("abort_cs_n", 32'(bus.spi_cs_n), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_rx_data", bus.rx_data, 32'd0);
        reset    = 1'b0;
        rx_model = 32'd0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("abort_no_done", 32'(bus.done), 32'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(2, 32'h0000BEEF, 32'h00001234);
        waitIdle("complete_after_abort");

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI mode-0 controller for the PET clone. Drives spi_sclk and spi_cs_n, shifts out up to MAX_LEN bytes MSB-first, and captures the same number of bytes from the target.
- Counterpart of our byte-oriented SPI target. Targets sample on the SCLK rising edge, shift on the falling edge, and preload bit 7 when CS falls.
- Used for FPGA-initiated transfers to the MCU and to peripherals, and as the bench stimulus master for the target.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period. Legal range is ≥2.
- MAX_LEN, 4: maximum bytes per transaction.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transaction. Sampled only while idle.
- length  in  3  byte count for this transaction.
- tx_data  in  8*MAX_LEN  bytes to send. Byte i is in [8i+7:8i]; byte 0 is sent first.
- rx_data  out  8*MAX_LEN  bytes received, same packing as tx_data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a transaction.
- spi_sclk  out  1  SPI clock. Idles low.
- spi_cs_n  out  1  chip select, active low. Idles high.
- spi_tx  out  1  MOSI.
- spi_rx  in  1  MISO.

Behaviour:
- Reset values: spi_sclk=0, spi_cs_n=1, spi_tx=0, busy=0, done=0, rx_data=0. All counters are 0 and the state is IDLE.
- Reset mid-transaction takes effect on the next edge regardless of state. It forces the reset values, and no done pulse is generated.
- Accepting start (IDLE, start=1):
  - tx_data and length are latched. Inputs may change afterwards.
  - length > MAX_LEN is clamped to MAX_LEN.
- States:
  - IDLE
    - On accepted start with length=0: no CS activity. busy stays 0; done pulses on the next cycle.
    - On accepted start with length≠0: the next cycle has spi_cs_n=0, busy=1, spi_tx=byte0[7]. Go to SETUP.
  - SETUP: hold for CLK_DIV cycles, then spi_sclk←1 and go to HIGH.
  - HIGH
    - On the edge that raises sclk, sample spi_rx into the shift register.
    - After CLK_DIV cycles, spi_sclk←0.
    - If bits remain, spi_tx←next bit (same edge) and go to LOW. Otherwise go to HOLD.
  - LOW: after CLK_DIV cycles, spi_sclk←1 and go to HIGH.
  - HOLD: sclk stays low for CLK_DIV cycles, then spi_cs_n←1 and go to GAP.
  - GAP: cs_n stays high for CLK_DIV cycles, then busy←0 and done←1 for one cycle. Return to IDLE.
- On the 8th sample of byte i, rx_data byte i is written on the same edge. Bytes at index ≥ length keep their prior values. rx_data holds until overwritten or reset.
- Bit order:
  - Within a byte: MSB first.
  - Across bytes: byte 0 first.
  - After bit 0 of byte i, spi_tx presents byte i+1 bit 7 on that falling edge.
- Latency: let D=CLK_DIV and N=clamped length ≥1. The start-accept edge is cycle 0.
  - cs_n falls at cycle 1.
  - First sclk rise is at 1+D.
  - Last sclk fall is at 1+16ND.
  - cs_n rises at 1+16ND+D.
  - done is at 1+16ND+2D.
- start is ignored while busy or while done=1. Back-to-back transactions are therefore separated by at least D cycles with cs_n high.
- The counters are:
  - a half-period counter of clog2(CLK_DIV) bits;
  - a 3-bit bit counter that wraps 7→0 per byte;
  - a byte counter compared to the latched length. No counter overflows, given the clamp.
- spi_sclk, spi_cs_n and spi_tx are driven directly from flops, with no combinational outputs.

Test Plan:
- D=2, length=1, tx=0xA5, target loopback returns 0x3C:
  - cs_n falls at cycle 1 and sclk rises at cycles 3,7,…,31.
  - MOSI carries bits 1,0,1,0,0,1,0,1.
  - cs_n rises at 35 and done pulses at 37.
  - rx_data[7:0]=0x3C.
- D=4, length=4, tx=0x44332211, target returns 0xDDCCBBAA:
  - rx_data=0xDDCCBBAA with 32 sclk rising edges.
  - done at cycle 1+256+8=265.
- length=6 (clamped to 4) with prior rx_data=0: exactly 32 sclk edges. Then length=2 with tx=0xFFFF: only rx bytes 0–1 change, bytes 2–3 are retained.
- length=0: done at cycle 1, cs_n never low, busy stays 0, rx_data unchanged.
- start held high continuously: each transaction is separated by ≥D cycles of cs_n high, and start pulses while busy (incl. mid-HIGH) are ignored.
- reset asserted mid-byte 1 while sclk=1:
  - The next cycle shows sclk=0, cs_n=1, busy=0, rx_data=0, and no done pulse.
  - A subsequent transaction completes correctly.
